// File: rtl/laser500_memmap_if.sv
// Bus bundle between the mapper, the T80s CPU bus, the SDRAM controller and the
// memory-mapped I/O block.
interface laser500_memmap_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_mreq_n;
  logic        cpu_iorq_n;
  logic        cpu_rd_n;
  logic        cpu_wr_n;
  logic        cpu_m1_n;
  logic [7:0]  cpu_din;
  logic        cpu_wait_n;
  logic [24:0] sdram_addr;
  logic [7:0]  sdram_din;
  logic        sdram_we;
  logic        sdram_req;
  logic        sdram_ack;
  logic [7:0]  sdram_dout;
  logic        mmio_sel;
  logic        mmio_we;
  logic [7:0]  mmio_din;
  logic        timeout_err;

  modport slave (
    input  cpu_addr, cpu_dout, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n,
    input  sdram_ack, sdram_dout, mmio_din,
    output cpu_din, cpu_wait_n, sdram_addr, sdram_din, sdram_we, sdram_req,
    output mmio_sel, mmio_we, timeout_err
  );

  modport master (
    output cpu_addr, cpu_dout, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n,
    output sdram_ack, sdram_dout, mmio_din,
    input  cpu_din, cpu_wait_n, sdram_addr, sdram_din, sdram_we, sdram_req,
    input  mmio_sel, mmio_we, timeout_err
  );
endinterface

// File: rtl/laser500_memmap.sv
// Laser 500 memory/IO mapper: four 16 KB bank registers, ROM write protection,
// memory-mapped I/O page decode and a req/ack SDRAM handshake that stalls the CPU.
module laser500_memmap #(
  parameter logic [15:0] RESET_BANKS    = 16'h7410,
  parameter logic [3:0]  ROM_LAST_PAGE  = 4'd1,
  parameter logic [3:0]  IO_PAGE        = 4'd2,
  parameter logic [3:0]  RAM_FIRST_PAGE = 4'd4,
  parameter logic [3:0]  RAM_LAST_PAGE  = 4'd7,
  parameter int unsigned ACK_TIMEOUT    = 63
) (
  input logic              F14M,
  input logic              RESET_n,
  laser500_memmap_if.slave bus
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t           state, state_nxt;
  logic [3:0][3:0]  banks, banks_nxt;
  logic [7:0]       cpu_din, cpu_din_nxt;
  logic             cpu_wait_n, cpu_wait_n_nxt;
  logic [24:0]      sdram_addr, sdram_addr_nxt;
  logic [7:0]       sdram_din, sdram_din_nxt;
  logic             sdram_we, sdram_we_nxt;
  logic             sdram_req, sdram_req_nxt;
  logic             mmio_sel, mmio_sel_nxt;
  logic             mmio_we, mmio_we_nxt;
  logic             timeout_err, timeout_err_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic       is_wr, mem_start, io_start, bank_port;
  logic       is_rom, is_io_page, is_ram;
  logic [3:0] page;

  // Interrupt acknowledge (iorq_n and m1_n both low) never counts as an I/O access.
  assign is_wr      = !bus.cpu_wr_n;
  assign mem_start  = !bus.cpu_mreq_n && (!bus.cpu_rd_n || !bus.cpu_wr_n);
  assign io_start   = !bus.cpu_iorq_n && bus.cpu_m1_n && (!bus.cpu_rd_n || !bus.cpu_wr_n);
  assign bank_port  = (bus.cpu_addr[7:2] == 6'b010000);
  assign page       = banks[bus.cpu_addr[15:14]];
  assign is_rom     = (page <= ROM_LAST_PAGE);
  assign is_io_page = (page == IO_PAGE);
  assign is_ram     = (page >= RAM_FIRST_PAGE) && (page <= RAM_LAST_PAGE);

  always_ff @(posedge F14M or negedge RESET_n) begin
    if (!RESET_n) begin
      state       <= IDLE;
      banks       <= RESET_BANKS;
      cpu_din     <= 8'hFF;
      cpu_wait_n  <= 1'b1;
      sdram_addr  <= '0;
      sdram_din   <= '0;
      sdram_we    <= 1'b0;
      sdram_req   <= 1'b0;
      mmio_sel    <= 1'b0;
      mmio_we     <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_nxt;
      banks       <= banks_nxt;
      cpu_din     <= cpu_din_nxt;
      cpu_wait_n  <= cpu_wait_n_nxt;
      sdram_addr  <= sdram_addr_nxt;
      sdram_din   <= sdram_din_nxt;
      sdram_we    <= sdram_we_nxt;
      sdram_req   <= sdram_req_nxt;
      mmio_sel    <= mmio_sel_nxt;
      mmio_we     <= mmio_we_nxt;
      timeout_err <= timeout_err_nxt;
      cnt         <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    banks_nxt       = banks;
    cpu_din_nxt     = cpu_din;
    cpu_wait_n_nxt  = cpu_wait_n;
    sdram_addr_nxt  = sdram_addr;
    sdram_din_nxt   = sdram_din;
    sdram_we_nxt    = sdram_we;
    sdram_req_nxt   = sdram_req;
    mmio_sel_nxt    = 1'b0;
    mmio_we_nxt     = 1'b0;
    timeout_err_nxt = 1'b0;
    cnt_nxt         = cnt;

    // The I/O block answers while its strobe is high; capture it on that cycle.
    if (mmio_sel && !mmio_we) cpu_din_nxt = bus.mmio_din;

    unique case (state)
      IDLE: begin
        if (mem_start) begin
          state_nxt = HOLD;
          if (is_ram || (is_rom && !is_wr)) begin
            state_nxt      = REQ;
            sdram_req_nxt  = 1'b1;
            sdram_we_nxt   = is_wr;
            sdram_addr_nxt = {7'd0, page, bus.cpu_addr[13:0]};
            sdram_din_nxt  = bus.cpu_dout;
            cpu_wait_n_nxt = 1'b0;
            cnt_nxt        = '0;
          end else if (is_io_page) begin
            mmio_sel_nxt = 1'b1;
            mmio_we_nxt  = is_wr;
          end else if (!is_rom && !is_wr) begin
            cpu_din_nxt = 8'hFF;
          end
        end else if (io_start) begin
          state_nxt = HOLD;
          if (bank_port) begin
            if (is_wr) banks_nxt[bus.cpu_addr[1:0]] = bus.cpu_dout[3:0];
            else       cpu_din_nxt = {4'h0, banks[bus.cpu_addr[1:0]]};
          end else if (!is_wr) begin
            cpu_din_nxt = 8'hFF;
          end
        end
      end
      REQ: begin
        if (bus.sdram_ack) begin
          state_nxt      = HOLD;
          sdram_req_nxt  = 1'b0;
          sdram_we_nxt   = 1'b0;
          cpu_wait_n_nxt = 1'b1;
          if (!sdram_we) cpu_din_nxt = bus.sdram_dout;
        end else if (cnt == CNT_LAST) begin
          state_nxt       = HOLD;
          sdram_req_nxt   = 1'b0;
          sdram_we_nxt    = 1'b0;
          cpu_wait_n_nxt  = 1'b1;
          cpu_din_nxt     = 8'hFF;
          timeout_err_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOLD: begin
        // One request per bus cycle: wait for the CPU to drop its strobes.
        if (bus.cpu_mreq_n && bus.cpu_iorq_n) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cpu_din     = cpu_din;
  assign bus.cpu_wait_n  = cpu_wait_n;
  assign bus.sdram_addr  = sdram_addr;
  assign bus.sdram_din   = sdram_din;
  assign bus.sdram_we    = sdram_we;
  assign bus.sdram_req   = sdram_req;
  assign bus.mmio_sel    = mmio_sel;
  assign bus.mmio_we     = mmio_we;
  assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_laser500_memmap.sv
// Randomized scoreboard bench for laser500_memmap: a bank/page reference model
// predicts SDRAM requests, I/O strobes and CPU read data; a monitor compares them.
module tb_laser500_memmap;
  localparam int ACK_TIMEOUT = 63;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  laser500_memmap_if bus();
  laser500_memmap dut (.F14M(clk), .RESET_n(rst_n), .bus(bus));

  typedef struct { logic [24:0] addr; logic we; logic [7:0] din; } req_t;
  typedef struct { logic skip; logic [7:0] data; } rd_t;

  req_t req_q[$];
  logic mmio_q[$];
  rd_t  rd_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int tmo_exp  = 0;
  int tmo_seen = 0;
  int late_ack_req = 0;
  logic ack_hold = 1'b0;

  int         mbanks[4];
  logic [7:0] mdin;
  logic [7:0] ref_mem [int];
  logic [7:0] sd_mem  [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 37) ^ (a >> 7));
  endfunction

  task automatic model_reset();
    mbanks = '{0, 1, 4, 7};
    mdin   = 8'hFF;
  endtask

  // One CPU bus cycle: predict the outcome, then drive the strobes until WAIT clears.
  task automatic bus_cycle(input bit io, input bit wr, input logic [15:0] addr,
                           input logic [7:0] data, input bit m1_low,
                           input bit hold_ack, input int hold);
    bit         exp_wait;
    logic [7:0] exp_rd;
    int         page;
    int         sa;
    logic [7:0] mval;
    int         n;
    exp_wait = 1'b0;
    exp_rd   = mdin;
    mval     = 8'($urandom);
    if (io) begin
      if (!m1_low && addr[7:0] >= 8'h40 && addr[7:0] <= 8'h43) begin
        if (wr) mbanks[addr % 4] = data % 16;
        else    exp_rd = 8'(mbanks[addr % 4]);
      end else if (!m1_low && !wr) begin
        exp_rd = 8'hFF;
      end
    end else begin
      page = mbanks[addr / 16384];
      sa   = page * 16384 + addr % 16384;
      if ((page >= 4 && page <= 7) || (page <= 1 && !wr)) begin
        exp_wait = 1'b1;
        req_q.push_back('{25'(sa), wr, data});
        if (hold_ack) begin
          exp_rd = 8'hFF;
          mdin   = 8'hFF;
          tmo_exp++;
        end else if (wr) begin
          ref_mem[sa] = data;
        end else begin
          exp_rd = ref_mem.exists(sa) ? ref_mem[sa] : init_byte(sa);
        end
      end else if (page == 2) begin
        mmio_q.push_back(wr);
        bus.mmio_din = mval;
        if (!wr) exp_rd = mval;
      end else if (!wr) begin
        exp_rd = 8'hFF;
      end
    end
    if (!wr) begin
      mdin = exp_rd;
      rd_q.push_back('{1'b0, exp_rd});
    end
    ack_hold = hold_ack;

    @(posedge clk); #2;
    bus.cpu_addr = addr;
    bus.cpu_dout = data;
    bus.cpu_m1_n = !m1_low;
    if (io) bus.cpu_iorq_n = 1'b0; else bus.cpu_mreq_n = 1'b0;
    if (wr) bus.cpu_wr_n = 1'b0;   else bus.cpu_rd_n = 1'b0;
    @(posedge clk); #1;
    check("wait_latency", bus.cpu_wait_n, !exp_wait);
    #1;
    n = 0;
    while (!bus.cpu_wait_n && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    check("wait_release", bus.cpu_wait_n, 1);
    repeat (hold + 1) begin
      @(posedge clk); #2;
    end
    bus.cpu_mreq_n = 1'b1;
    bus.cpu_iorq_n = 1'b1;
    bus.cpu_rd_n   = 1'b1;
    bus.cpu_wr_n   = 1'b1;
    bus.cpu_m1_n   = 1'b1;
  endtask

  // Read from RAM, never acknowledged, abandoned by an asynchronous reset.
  task automatic reset_mid_req();
    bus_cycle(1'b1, 1'b1, 16'h0043, 8'h06, 1'b0, 1'b0, 0);
    req_q.push_back('{25'(6 * 16384 + 16'h0123), 1'b0, 8'h00});
    rd_q.push_back('{1'b1, 8'h00});
    ack_hold = 1'b1;
    @(posedge clk); #2;
    bus.cpu_addr   = 16'hC123;
    bus.cpu_dout   = 8'h00;
    bus.cpu_mreq_n = 1'b0;
    bus.cpu_rd_n   = 1'b0;
    @(posedge clk); #1;
    check("rst_wait_low", bus.cpu_wait_n, 0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_async_req", bus.sdram_req, 0);
    check("rst_async_wait", bus.cpu_wait_n, 1);
    check("rst_async_din", bus.cpu_din, 8'hFF);
    check("rst_async_addr", bus.sdram_addr, 0);
    check("rst_async_we", bus.sdram_we, 0);
    bus.cpu_mreq_n = 1'b1;
    bus.cpu_rd_n   = 1'b1;
    model_reset();
    @(posedge clk); #2 rst_n = 1'b1;
    late_ack_req++;
    repeat (3) @(posedge clk);
    #1;
    check("late_ack_din", bus.cpu_din, 8'hFF);
    check("late_ack_wait", bus.cpu_wait_n, 1);
    check("late_ack_req", bus.sdram_req, 0);
  endtask

  // SDRAM responder backed by its own memory image.
  initial begin
    int done;
    int d;
    done = 0;
    bus.sdram_ack  = 1'b0;
    bus.sdram_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (late_ack_req != done) begin
        done = late_ack_req;
        bus.sdram_dout = 8'h99;
        bus.sdram_ack  = 1'b1;
        @(negedge clk);
        bus.sdram_ack  = 1'b0;
      end else if (bus.sdram_req && !ack_hold) begin
        d = $urandom_range(0, 4);
        repeat (d) @(negedge clk);
        if (bus.sdram_req && !ack_hold) begin
          if (bus.sdram_we) sd_mem[int'(bus.sdram_addr)] = bus.sdram_din;
          else bus.sdram_dout = sd_mem.exists(int'(bus.sdram_addr)) ?
                                sd_mem[int'(bus.sdram_addr)] : init_byte(int'(bus.sdram_addr));
          bus.sdram_ack = 1'b1;
          @(negedge clk);
          bus.sdram_ack = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expectations as the DUT presents requests, strobes and read data.
  initial begin
    logic prev_rd, prev_req, prev_sel, prev_tmo;
    int   run, last_run;
    req_t e;
    rd_t  r;
    prev_rd = 1'b1; prev_req = 1'b0; prev_sel = 1'b0; prev_tmo = 1'b0;
    run = 0; last_run = 0;
    forever begin
      @(negedge clk);
      check("wait_vs_req", bus.cpu_wait_n, !bus.sdram_req);
      if (bus.sdram_req) run++;
      else if (prev_req) begin
        last_run = run;
        run = 0;
      end
      if (bus.sdram_req && !prev_req) begin
        if (req_q.size() == 0) check("unexpected_req", 1, 0);
        else begin
          e = req_q.pop_front();
          check("sdram_addr", bus.sdram_addr, e.addr);
          check("sdram_we", bus.sdram_we, e.we);
          if (e.we) check("sdram_din", bus.sdram_din, e.din);
        end
      end
      if (bus.mmio_sel) begin
        check("mmio_single", prev_sel, 0);
        if (mmio_q.size() == 0) check("unexpected_mmio", 1, 0);
        else check("mmio_we", bus.mmio_we, mmio_q.pop_front());
      end
      if (bus.timeout_err) begin
        tmo_seen++;
        check("timeout_single", prev_tmo, 0);
        check("timeout_cycles", last_run, ACK_TIMEOUT);
      end
      if (bus.cpu_rd_n && !prev_rd) begin
        if (rd_q.size() == 0) check("unexpected_rd", 1, 0);
        else begin
          r = rd_q.pop_front();
          if (!r.skip) check("cpu_din", bus.cpu_din, r.data);
        end
      end
      prev_rd  = bus.cpu_rd_n;
      prev_req = bus.sdram_req;
      prev_sel = bus.mmio_sel;
      prev_tmo = bus.timeout_err;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    logic [15:0] a;
    logic [7:0]  v;
    bus.cpu_addr   = '0;
    bus.cpu_dout   = '0;
    bus.cpu_mreq_n = 1'b1;
    bus.cpu_iorq_n = 1'b1;
    bus.cpu_rd_n   = 1'b1;
    bus.cpu_wr_n   = 1'b1;
    bus.cpu_m1_n   = 1'b1;
    bus.mmio_din   = '0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_din", bus.cpu_din, 8'hFF);
    check("reset_wait", bus.cpu_wait_n, 1);
    check("reset_req", bus.sdram_req, 0);
    check("reset_we", bus.sdram_we, 0);
    check("reset_mmio_sel", bus.mmio_sel, 0);
    check("reset_mmio_we", bus.mmio_we, 0);
    check("reset_timeout", bus.timeout_err, 0);
    check("reset_addr", bus.sdram_addr, 0);
    check("reset_sdin", bus.sdram_din, 0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 4; i++) bus_cycle(1'b1, 1'b0, 16'(16'h0040 + i), 8'h00, 1'b0, 1'b0, 0);
    bus_cycle(1'b1, 1'b1, 16'h0041, 8'h05, 1'b0, 1'b0, 0);
    sd_mem[32'h14123]  = 8'h5A;
    ref_mem[32'h14123] = 8'h5A;
    bus_cycle(1'b0, 1'b0, 16'h4123, 8'h00, 1'b0, 1'b0, 0);
    bus_cycle(1'b0, 1'b1, 16'h0010, 8'h33, 1'b0, 1'b0, 0);
    bus_cycle(1'b0, 1'b1, 16'hC000, 8'h33, 1'b0, 1'b0, 0);
    bus_cycle(1'b0, 1'b0, 16'hC000, 8'h00, 1'b0, 1'b0, 0);
    bus_cycle(1'b1, 1'b1, 16'h0042, 8'h02, 1'b0, 1'b0, 0);
    bus_cycle(1'b0, 1'b0, 16'h8000, 8'h00, 1'b0, 1'b0, 9);
    bus_cycle(1'b0, 1'b1, 16'h8001, 8'h77, 1'b0, 1'b0, 2);
    bus_cycle(1'b0, 1'b0, 16'hFFFF, 8'h00, 1'b0, 1'b0, 0);
    bus_cycle(1'b0, 1'b0, 16'hC010, 8'h00, 1'b0, 1'b1, 0);
    bus_cycle(1'b1, 1'b0, 16'h0055, 8'h00, 1'b0, 1'b0, 0);
    bus_cycle(1'b1, 1'b0, 16'h0040, 8'h00, 1'b1, 1'b0, 0);

    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      a = 16'($urandom);
      v = 8'($urandom);
      if (k == 0) begin
        if ($urandom_range(0, 3) == 0) v = 8'($urandom_range(0, 15));
        else v = 8'($urandom_range(4, 7));
        bus_cycle(1'b1, 1'b1, 16'(16'h0040 + $urandom_range(0, 3)), v, 1'b0, 1'b0, 0);
      end else if (k == 1) begin
        bus_cycle(1'b1, 1'b0, 16'(16'h0040 + $urandom_range(0, 3)), 8'h00, 1'b0, 1'b0, 0);
      end else if (k == 2) begin
        if (a[7:2] == 6'b010000) a[7] = 1'b1;
        bus_cycle(1'b1, 1'($urandom_range(0, 1)), a, v, 1'b0, 1'b0, 0);
      end else if (k == 3) begin
        bus_cycle(1'b1, 1'b0, 16'h0041, 8'h00, 1'b1, 1'b0, 0);
      end else begin
        if ($urandom_range(0, 7) == 0) a = 16'hFFFF;
        bus_cycle(1'b0, 1'($urandom_range(0, 1)), a, v, 1'b0,
                  ($urandom_range(0, 19) == 0), $urandom_range(0, 3));
      end
    end

    reset_mid_req();
    for (int i = 0; i < 4; i++) bus_cycle(1'b1, 1'b0, 16'(16'h0040 + i), 8'h00, 1'b0, 1'b0, 0);

    repeat (5) @(posedge clk);
    #1;
    check("req_q_drained", req_q.size(), 0);
    check("mmio_q_drained", mmio_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    check("timeout_count", tmo_seen, tmo_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/laser500_memmap.md
Name: laser500_memmap

Overview:
- Memory/IO mapper between the T80s CPU and the SDRAM controller, clocked by F14M.
- Holds the four 16 KB bank registers (I/O ports 0x40-0x43) and translates CPU addresses into 25-bit SDRAM page addresses.
- Blocks writes to ROM pages and decodes the memory-mapped I/O page.
- Runs a req/ack handshake with the SDRAM side, holding the CPU in WAIT until data is returned.

Parameters:
- RESET_BANKS, 16'h7410: reset page per bank, nibble i = bank i (bank0=0, bank1=1, bank2=4, bank3=7).
- ROM_LAST_PAGE, 1: pages 0..ROM_LAST_PAGE are ROM (write-protected).
- IO_PAGE, 2: page decoded as memory-mapped I/O.
- RAM_FIRST_PAGE, 4: first RAM page.
- RAM_LAST_PAGE, 7: last RAM page. Pages outside ROM, IO and RAM are unmapped.
- ACK_TIMEOUT, 63: maximum F14M cycles to wait for sdram_ack.

Ports:
- F14M  in  1  system clock, CPU bus sampled on rising edge (CPUCK derived from it).
- RESET_n  in  1  asynchronous active-low reset.
- cpu_addr  in  16  CPU address.
- cpu_dout  in  8  CPU write data.
- cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n  in  1 each  Z80 bus strobes.
- cpu_din  out  8  registered read data to CPU.
- cpu_wait_n  out  1  registered WAIT to CPU.
- sdram_addr  out  25  {7'd0, page[3:0], cpu_addr[13:0]}.
- sdram_din  out  8  write data (cpu_dout latched).
- sdram_we  out  1  write qualifier, valid while sdram_req=1.
- sdram_req  out  1  access request, level.
- sdram_ack  in  1  one-cycle completion pulse; sdram_dout valid in the same cycle.
- sdram_dout  in  8  read data.
- mmio_sel  out  1  one-cycle strobe, memory access to IO_PAGE.
- mmio_we  out  1  qualifies mmio_sel as write.
- mmio_din  in  8  read data from memory-mapped I/O, sampled with mmio_sel.
- timeout_err  out  1  one-cycle pulse on ack timeout.

Behaviour:
- Reset, asynchronous on RESET_n=0:
  - banks = RESET_BANKS; state=IDLE.
  - cpu_din=8'hFF, cpu_wait_n=1.
  - sdram_req=0, sdram_we=0, mmio_sel=0, mmio_we=0, timeout_err=0, sdram_addr=0, sdram_din=0.
- Reset mid-access abandons the access immediately; no ack is expected afterwards, and an ack arriving in IDLE is ignored.
- Address mapping: page = banks[cpu_addr[15:14]].
- Start condition (evaluated only in IDLE):
  - mem = !mreq_n & (!rd_n | !wr_n).
  - io = !iorq_n & m1_n & (!rd_n | !wr_n). Interrupt-acknowledge (iorq_n & m1_n both low) is ignored.
- States: IDLE, REQ, HOLD.
- IDLE, io start, port[7:2]==6'b010000 (0x40-0x43):
  - write: banks[addr[1:0]] <= cpu_dout[3:0].
  - read: cpu_din <= {4'h0, bank}.
  - No wait is inserted; go to HOLD.
- IDLE, io start, other ports: read sets cpu_din=8'hFF; go to HOLD.
- IDLE, mem start, RAM page (read or write), or ROM page read:
  - Next cycle: sdram_req=1, sdram_we=!wr_n, address and data latched, cpu_wait_n=0, timeout counter cleared.
  - Go to REQ. The latency from start edge to cpu_wait_n=0 is exactly 1 cycle.
- IDLE, mem start, ROM page write: dropped, no request issued; go to HOLD.
- IDLE, mem start, IO_PAGE: mmio_sel pulses 1 cycle with mmio_we=!wr_n; a read latches mmio_din into cpu_din; go to HOLD.
- IDLE, mem start, unmapped page: read sets cpu_din=8'hFF, write dropped; go to HOLD.
- REQ:
  - On sdram_ack: sdram_req=0; on a read, cpu_din<=sdram_dout; cpu_wait_n=1 next cycle; go to HOLD.
  - If the counter reaches ACK_TIMEOUT without ack: sdram_req=0, cpu_din=8'hFF, timeout_err pulses, cpu_wait_n=1; go to HOLD.
  - Bus strobes are not re-sampled in REQ (the CPU is frozen by WAIT).
- HOLD: stays until mreq_n & iorq_n are both high, then goes to IDLE. This guarantees exactly one request per bus cycle.
- Bank writes take effect for the next access; the bank write and the following memory cycle are never in the same cycle.
- Wrap-around: cpu_addr 16'hFFFF maps to page banks[3], offset 14'h3FFF; no carry into the page.

Test Plan:
- Reset release -> banks read via IN 0x40..0x43 return 0x00, 0x01, 0x04, 0x07; cpu_wait_n=1, sdram_req=0.
- OUT 0x41,0x05, then read 0x4123 -> sdram_addr=25'h0014123, sdram_we=0, wait_n low 1 cycle after start; ack with dout=0x5A -> cpu_din=0x5A, wait_n=1 next cycle.
- Write 0x33 to 0x0010 (ROM page 0) -> no sdram_req, no wait, cpu_wait_n stays 1; write to RAM 0xC000 -> sdram_addr=25'h001C000, sdram_din=0x33, sdram_we=1.
- Read 0x8000 with bank2 set to IO_PAGE, mmio_din=0x3C -> single-cycle mmio_sel, cpu_din=0x3C, no sdram_req; strobes held 10 cycles -> still only one strobe.
- Read RAM, withhold ack -> after 63 cycles timeout_err pulses once, cpu_din=0xFF, cpu_wait_n=1, sdram_req=0.
- RESET_n low while in REQ -> outputs immediately return to reset values; a late ack in IDLE causes no change.
